// File: rtl/pc_register_if.sv
// Program-counter bus: next-PC load port from the control/mux side and the
// registered PC (plus its top-bit slice) returned to the jump-target logic.
interface pc_register_if #(
  parameter int WIDTH    = 16,
  parameter int TOP_BITS = 3
);
  logic [WIDTH-1:0]    Din;
  logic                PCWrite;
  logic [WIDTH-1:0]    Out;
  logic [TOP_BITS-1:0] TopOut;

  modport master (
    output Din,
    output PCWrite,
    input  Out,
    input  TopOut
  );

  modport slave (
    input  Din,
    input  PCWrite,
    output Out,
    output TopOut
  );
endinterface

// File: rtl/pc_register.sv
// Program-counter holding register: pure load/hold, async active-low reset to
// the boot address, top bits sliced out for jump-target concatenation.
module pc_register #(
  parameter int               WIDTH       = 16,
  parameter int               TOP_BITS    = 3,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic         CLK,
  input  logic         RST_N,
  pc_register_if.slave bus
);

  logic [WIDTH-1:0] pc;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc <= RESET_VALUE;
    end else if (bus.PCWrite) begin
      pc <= bus.Din;
    end
  end

  // Both outputs come straight off the register; no path from Din/PCWrite.
  assign bus.Out    = pc;
  assign bus.TopOut = pc[WIDTH-1 -: TOP_BITS];

endmodule

// File: tb/tb_pc_register.sv
// Self-checking bench for pc_register: directed scenarios plus randomized
// load/hold/reset traffic against a behavioural PC model.
module tb_pc_register;

  localparam int WIDTH    = 16;
  localparam int TOP_BITS = 3;

  logic CLK;
  logic RST_N;
  int   errors;
  int   checks;
  logic [WIDTH-1:0]    exp_pc;
  logic [TOP_BITS-1:0] exp_top;

  pc_register_if #(.WIDTH(WIDTH), .TOP_BITS(TOP_BITS)) bus ();

  pc_register #(
    .WIDTH      (WIDTH),
    .TOP_BITS   (TOP_BITS),
    .RESET_VALUE(16'h0000)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Model: at each rising edge the PC becomes 0 under reset, Din when enabled,
  // else unchanged; the top field is the PC divided by 2^(WIDTH-TOP_BITS).
  task automatic model_edge();
    if (!RST_N) exp_pc = 16'h0000;
    else if (bus.PCWrite) exp_pc = bus.Din;
    exp_top = TOP_BITS'(exp_pc / (1 << (WIDTH - TOP_BITS)));
  endtask

  task automatic clock_and_settle();
    if ($isunknown(bus.PCWrite)) begin
      checks++;
      errors++;
      $display("FAIL pcwrite_known: PCWrite=%b at clock edge", bus.PCWrite);
    end
    model_edge();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    bus.Din = 16'hFFFF;
    bus.PCWrite = 1'b1;
    #1;
    checks++;
    if (bus.Out !== 16'h0000 || bus.TopOut !== 3'b000) begin
      errors++;
      $display("FAIL reset_initial: Out=%h TopOut=%b expected 0000/000", bus.Out, bus.TopOut);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      clock_and_settle();
      checks++;
      if (bus.Out !== 16'h0000 || bus.TopOut !== 3'b000) begin
        errors++;
        $display("FAIL reset_hold[%0d]: Out=%h TopOut=%b expected 0000/000", i, bus.Out, bus.TopOut);
      end
    end
    exp_pc = 16'h0000;
  endtask

  task automatic test_single_load();
    @(negedge CLK);
    RST_N = 1'b1;
    bus.PCWrite = 1'b0;
    @(negedge CLK);
    bus.Din = 16'h4096;
    bus.PCWrite = 1'b1;
    clock_and_settle();
    checks++;
    if (bus.Out !== 16'h4096 || bus.TopOut !== 3'b010) begin
      errors++;
      $display("FAIL single_load: Out=%h TopOut=%b expected 4096/010", bus.Out, bus.TopOut);
    end
    @(negedge CLK);
    bus.PCWrite = 1'b0;
  endtask

  task automatic test_hold();
    bus.Din = 16'h027A;
    bus.PCWrite = 1'b0;
    for (int i = 0; i < 4; i++) begin
      clock_and_settle();
      checks++;
      if (bus.Out !== 16'h4096 || bus.TopOut !== 3'b010) begin
        errors++;
        $display("FAIL hold[%0d]: Out=%h TopOut=%b expected 4096/010", i, bus.Out, bus.TopOut);
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0]    vals [3];
    logic [TOP_BITS-1:0] tops [3];
    vals = '{16'hE001, 16'h2000, 16'hFFFF};
    tops = '{3'b111, 3'b001, 3'b111};
    for (int i = 0; i < 3; i++) begin
      bus.Din = vals[i];
      bus.PCWrite = 1'b1;
      clock_and_settle();
      checks++;
      if (bus.Out !== vals[i] || bus.TopOut !== tops[i]) begin
        errors++;
        $display("FAIL back_to_back[%0d]: Out=%h TopOut=%b expected %h/%b", i, bus.Out, bus.TopOut, vals[i], tops[i]);
      end
      @(negedge CLK);
    end
    bus.PCWrite = 1'b0;
  endtask

  task automatic test_async_reset();
    // Out is 0xFFFF here; reset pulses between edges with no clock needed.
    #2;
    RST_N = 1'b0;
    #1;
    checks++;
    if (bus.Out !== 16'h0000 || bus.TopOut !== 3'b000) begin
      errors++;
      $display("FAIL async_reset: Out=%h TopOut=%b expected 0000/000", bus.Out, bus.TopOut);
    end
    RST_N = 1'b1;
    exp_pc = 16'h0000;
    bus.Din = 16'h5555;
    bus.PCWrite = 1'b0;
    for (int i = 0; i < 2; i++) begin
      clock_and_settle();
      checks++;
      if (bus.Out !== 16'h0000) begin
        errors++;
        $display("FAIL async_reset_hold[%0d]: Out=%h expected 0000", i, bus.Out);
      end
      @(negedge CLK);
    end
    bus.PCWrite = 1'b1;
    clock_and_settle();
    checks++;
    if (bus.Out !== 16'h5555 || bus.TopOut !== 3'b010) begin
      errors++;
      $display("FAIL async_reset_reload: Out=%h TopOut=%b expected 5555/010", bus.Out, bus.TopOut);
    end
    @(negedge CLK);
  endtask

  task automatic test_collision();
    RST_N = 1'b0;
    bus.Din = 16'h1234;
    bus.PCWrite = 1'b1;
    clock_and_settle();
    checks++;
    if (bus.Out !== 16'h0000 || bus.TopOut !== 3'b000) begin
      errors++;
      $display("FAIL collision: Out=%h TopOut=%b expected 0000/000", bus.Out, bus.TopOut);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    bus.PCWrite = 1'b1;
    clock_and_settle();
    checks++;
    if (bus.Out !== 16'h1234) begin
      errors++;
      $display("FAIL release_with_write: Out=%h expected 1234", bus.Out);
    end
    @(negedge CLK);
    bus.PCWrite = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      RST_N = ($urandom_range(0, 19) != 0);
      bus.PCWrite = $urandom_range(0, 1);
      bus.Din = WIDTH'($urandom);
      if (!RST_N) begin
        #1;
        checks++;
        if (bus.Out !== 16'h0000) begin
          errors++;
          $display("FAIL random_async[%0d]: Out=%h expected 0000", i, bus.Out);
        end
      end
      clock_and_settle();
      checks++;
      if (bus.Out !== exp_pc || bus.TopOut !== exp_top) begin
        errors++;
        $display("FAIL random[%0d]: Out=%h TopOut=%b expected %h/%b", i, bus.Out, bus.TopOut, exp_pc, exp_top);
      end
      @(negedge CLK);
    end
    RST_N = 1'b1;
    bus.PCWrite = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    exp_pc = 16'h0000;
    exp_top = 3'b000;
    test_reset();
    test_single_load();
    test_hold();
    test_back_to_back();
    test_async_reset();
    test_collision();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_register.md
# pc_register

Program-counter holding register for the 16-bit accumulator processor datapath. It stores the current instruction address and loads a new value from the next-PC mux only when the control unit asserts the PC write enable. It also exposes the upper three address bits separately, so jump-target logic can concatenate them with an instruction's immediate field.

## Interface
- WIDTH, default 16: PC width in bits.
- TOP_BITS, default 3: number of most-significant PC bits driven on TopOut.
- RESET_VALUE, default 16'h0000: value loaded on reset (boot address).

- CLK  input  1  system clock; all state changes on the rising edge.
- RST_N  input  1  reset, asynchronous, active-low; clears the PC to RESET_VALUE.
- Din  input  WIDTH  next PC value from the next-PC mux.
- PCWrite  input  1  load enable, active-high, sampled on the rising CLK edge.
- Out  output  WIDTH  current PC value, registered.
- TopOut  output  TOP_BITS  Out[WIDTH-1 : WIDTH-TOP_BITS], i.e. Out[15:13] by default.

## Operation
- Single WIDTH-bit state register, PC. There is no internal incrementer or arithmetic: the block is a pure load/hold register.
- RST_N low:
  - PC is forced to RESET_VALUE immediately, independent of CLK.
  - PC is held there while RST_N stays low; Din and PCWrite are ignored.
- RST_N high, rising CLK edge:
  - PCWrite = 1: PC <= Din, full WIDTH bits, no truncation or sign handling.
  - PCWrite = 0: PC holds its value. Din changes have no effect.
- Out is driven directly from PC, with no combinational path from Din or PCWrite.
- TopOut is a combinational slice of PC and always equals Out[15:13]. It is never independently registered.
- PCWrite = X or Z on a clock edge is illegal. The verification environment flags it; the design behaviour is unspecified.

## Timing
- Reset values: Out = RESET_VALUE (0x0000), TopOut = RESET_VALUE[15:13] (3'b000).
- Reset assertion takes effect asynchronously; outputs change within the same delta as RST_N falling.
- Reset deassertion is synchronized by the system. The first load can occur on the first rising CLK edge after RST_N is high and meets recovery time.
- Load latency is one clock. Din/PCWrite sampled at rising edge N appear on Out and TopOut after edge N, and are stable until at least edge N+1.
- Din and PCWrite must meet setup/hold around the rising CLK edge. Stimulus must change them away from the active edge (e.g. on the falling edge).
- Consecutive PCWrite cycles load a new value every clock. There is no back-pressure or handshake.
- Reset asserted in the same cycle as PCWrite = 1: reset wins, and PC = RESET_VALUE.
- Reset released while PCWrite = 1: loading starts at the first qualifying rising edge.

## Test plan
- Reset: with RST_N = 0 and Din = 0xFFFF, PCWrite = 1 for 3 clocks -> Out = 0x0000, TopOut = 3'b000 throughout.
- Single load: release reset, Din = 16534 (0x4096), PCWrite = 1 for one rising edge, then 0 -> Out = 0x4096, TopOut = 3'b010 after that edge.
- Hold: after the load, Din = 634 (0x027A) with PCWrite = 0 for 4 edges -> Out stays 0x4096, TopOut stays 3'b010.
- Back-to-back loads: PCWrite = 1 with Din = 0xE001, 0x2000, 0xFFFF on successive edges -> Out = 0xE001 (TopOut 3'b111), then 0x2000 (3'b001), then 0xFFFF (3'b111), each one edge after the stimulus.
- Async reset mid-operation: Out = 0xFFFF; pulse RST_N low between clock edges -> Out = 0x0000 immediately, with no clock edge needed. It stays 0x0000 until the next enabled load.
- Reset vs write collision: RST_N low and PCWrite = 1 with Din = 0x1234 on the same edge -> Out = 0x0000.
